// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter slice.
// Op codes, control width and arbiter FSM states.
package alu_pkg;

  localparam int ALU_CTL_W = 4;

  typedef enum logic [ALU_CTL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels of both requesters plus the ALU link.
// slave = arbiter side, master = requesters and ALU side.
interface alu_arbiter_if #(
  parameter int XLEN = 32
);
  import alu_pkg::*;

  logic                 req0_valid;
  logic                 req0_ready;
  logic [ALU_CTL_W-1:0] req0_ctl;
  logic [XLEN-1:0]      req0_src1;
  logic [XLEN-1:0]      req0_src2;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [ALU_CTL_W-1:0] req1_ctl;
  logic [XLEN-1:0]      req1_src1;
  logic [XLEN-1:0]      req1_src2;

  logic                 rsp0_valid;
  logic                 rsp0_ready;
  logic [XLEN-1:0]      rsp0_result;
  logic                 rsp0_zero;

  logic                 rsp1_valid;
  logic                 rsp1_ready;
  logic [XLEN-1:0]      rsp1_result;
  logic                 rsp1_zero;

  logic [ALU_CTL_W-1:0] alu_ctl;
  logic [XLEN-1:0]      alu_src1;
  logic [XLEN-1:0]      alu_src2;
  logic [XLEN-1:0]      alu_result;
  logic                 alu_zero;

  modport slave (
    input  req0_valid, req0_ctl, req0_src1, req0_src2,
    input  req1_valid, req1_ctl, req1_src1, req1_src2,
    input  rsp0_ready, rsp1_ready,
    input  alu_result, alu_zero,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero,
    output rsp1_valid, rsp1_result, rsp1_zero,
    output alu_ctl, alu_src1, alu_src2
  );

  modport master (
    output req0_valid, req0_ctl, req0_src1, req0_src2,
    output req1_valid, req1_ctl, req1_src1, req1_src2,
    output rsp0_ready, rsp1_ready,
    output alu_result, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero,
    input  rsp1_valid, rsp1_result, rsp1_zero,
    input  alu_ctl, alu_src1, alu_src2
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way combinational grant: fixed priority to 0, or the
// requester that did not win last time when both are valid.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  input  logic fixed_prio,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (1'b1)
      (valid0 && valid1): begin
        grant0 = fixed_prio || last;
        grant1 = !(fixed_prio || last);
      end
      (valid0 && !valid1): grant0 = 1'b1;
      (!valid0 && valid1): grant1 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between execute (0) and
// the address/branch-compare unit (1); one op in flight at a time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIXED_PRIO = 0
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  arb_state_t           state;
  logic                 rr_last;
  logic                 owner;
  logic [ALU_CTL_W-1:0] op_ctl;
  logic [XLEN-1:0]      op_src1;
  logic [XLEN-1:0]      op_src2;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_zero;
  logic [XLEN-1:0]      rsp_result [2];

  logic grant0;
  logic grant1;
  logic idle;
  logic own_ready;

  rr_arb2 u_arb (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last       (rr_last),
    .fixed_prio (FIXED_PRIO != 0),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  assign idle      = (state == IDLE);
  assign own_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready = idle && grant0;
  assign bus.req1_ready = idle && grant1;

  assign bus.alu_ctl  = op_ctl;
  assign bus.alu_src1 = op_src1;
  assign bus.alu_src2 = op_src2;

  assign bus.rsp0_valid  = rsp_valid[0];
  assign bus.rsp0_zero   = rsp_zero[0];
  assign bus.rsp0_result = rsp_result[0];
  assign bus.rsp1_valid  = rsp_valid[1];
  assign bus.rsp1_zero   = rsp_zero[1];
  assign bus.rsp1_result = rsp_result[1];

  // Grants only ever fire with their valid, so a grant in IDLE
  // is the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_last       <= 1'b1;
      owner         <= 1'b0;
      op_ctl        <= '0;
      op_src1       <= '0;
      op_src2       <= '0;
      rsp_valid     <= '0;
      rsp_zero      <= '0;
      rsp_result[0] <= '0;
      rsp_result[1] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant0: begin
              op_ctl  <= bus.req0_ctl;
              op_src1 <= bus.req0_src1;
              op_src2 <= bus.req0_src2;
              owner   <= 1'b0;
              rr_last <= 1'b0;
              state   <= EXEC;
            end
            grant1: begin
              op_ctl  <= bus.req1_ctl;
              op_src1 <= bus.req1_src1;
              op_src2 <= bus.req1_src2;
              owner   <= 1'b1;
              rr_last <= 1'b1;
              state   <= EXEC;
            end
            default: ;
          endcase
        end
        EXEC: begin
          rsp_valid[owner]  <= 1'b1;
          rsp_result[owner] <= bus.alu_result;
          rsp_zero[owner]   <= bus.alu_zero;
          state             <= RESP;
        end
        RESP: begin
          if (own_ready) begin
            rsp_valid[owner] <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
